// File: rtl/sram_access_ctrl.sv
// Single-word external SRAM access sequencer for the LC-3 MAR/MDR datapath.
// All pin-facing outputs are registered; strobe flops load from the next state.
module sram_access_ctrl #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  input  logic [DATA_W-1:0] dq_in
);

  if (RD_WAIT > 15) begin : g_bad_rd_wait
    $fatal(1, "sram_access_ctrl: RD_WAIT must be in 0..15");
  end
  if (WR_WAIT > 15) begin : g_bad_wr_wait
    $fatal(1, "sram_access_ctrl: WR_WAIT must be in 0..15");
  end

  localparam logic [3:0] RD_LAST = RD_WAIT[3:0];
  localparam logic [3:0] WR_LAST = WR_WAIT[3:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACC,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                byte_n_q, byte_n_d;
  logic                dq_oe_q, dq_oe_d;

  // Next state, wait counter and latched transfer operands
  always_comb begin
    state_d     = state_q;
    wcnt_d      = '0;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;

    case (state_q)
      S_IDLE: begin
        if (req_rd) begin
          state_d     = S_RD_ACC;
          sram_addr_d = addr;
        end else if (req_wr) begin
          state_d     = S_WR_SETUP;
          sram_addr_d = addr;
          dq_out_d    = wdata;
        end
      end
      S_RD_ACC: begin
        if (wcnt_q == RD_LAST) begin
          state_d = S_DONE;
          rdata_d = dq_in;
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        if (wcnt_q == WR_LAST) state_d = S_WR_HOLD;
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Counter restarts at zero on every state entry
    if ((state_d == state_q) && ((state_q == S_RD_ACC) || (state_q == S_WR_PULSE))) begin
      wcnt_d = wcnt_q + 4'd1;
    end
  end

  // Strobes decoded from the next state so the pins come straight from flops
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    byte_n_d = 1'b1;
    dq_oe_d  = 1'b0;

    case (state_d)
      S_RD_ACC: begin
        busy_d   = 1'b1;
        ce_n_d   = 1'b0;
        oe_n_d   = 1'b0;
        byte_n_d = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        busy_d   = 1'b1;
        ce_n_d   = 1'b0;
        byte_n_d = 1'b0;
        dq_oe_d  = 1'b1;
      end
      S_WR_PULSE: begin
        busy_d   = 1'b1;
        ce_n_d   = 1'b0;
        we_n_d   = 1'b0;
        byte_n_d = 1'b0;
        dq_oe_d  = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      byte_n_q    <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      byte_n_q    <= byte_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = byte_n_q;
  assign SRAM_LB_N = byte_n_q;
  assign dq_out    = dq_out_q;
  assign dq_oe     = dq_oe_q;

endmodule
